// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder feeding a 2-entry {inst, addr, err} FIFO; an accepted entry is on the outputs one edge later.
// Backpressure: o_ready is registered "not full", so a full FIFO refuses a push even when it pops in the same cycle.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_addr,
    output logic        o_err
);

    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;
    localparam logic [6:0]  OP_JALR  = 7'b1100111;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_ALUI  = 7'b0010011;
    localparam logic [6:0]  OP_BR    = 7'b1100011;
    localparam logic [6:0]  OP_ST    = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    fmt_e        fmt;
    logic [11:0] imm_i;
    logic [31:0] enc_inst;
    logic        enc_err;

    entry_t      mem_q [2];
    entry_t      head;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        ready_q;
    logic [31:0] addr_q, addr_d;
    logic        push, pop;

    always_comb begin
        fmt = FMT_BAD;
        case (i_opcode)
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_ALUI: fmt = FMT_I;
            OP_BR:                    fmt = FMT_B;
            OP_ST:                    fmt = FMT_S;
            OP_ALU:                   fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
    end

    // Immediate shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
    always_comb begin
        imm_i = i_imm[11:0];
        if (i_opcode == OP_ALUI && (i_funct3 == 3'b001 || i_funct3 == 3'b101)) begin
            imm_i = {i_funct7, i_imm[4:0]};
        end
    end

    always_comb begin
        enc_inst = NOP_INST;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R: enc_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: enc_inst = {imm_i, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: enc_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: begin
                enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                            i_imm[4:1], i_imm[11], i_opcode};
                enc_err  = i_imm[0];
            end
            FMT_U: enc_inst = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: begin
                enc_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_err  = i_imm[0];
            end
            default: begin
                enc_inst = NOP_INST;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign push = i_valid && ready_q;
    assign pop  = (count_q != 2'd0) && i_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            addr_d   = addr_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
            addr_q   <= BASE_ADDR;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != 2'd2);
            addr_q   <= addr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{inst: enc_inst, addr: addr_q, err: enc_err};
            end
        end
    end

    // Storage is never reset; the occupancy count alone gates what reaches the outputs.
    assign head    = mem_q[rd_ptr_q];
    assign o_ready = ready_q;
    assign o_valid = (count_q != 2'd0);
    assign o_inst  = o_valid ? head.inst : 32'h00000000;
    assign o_err   = o_valid ? head.err  : 1'b0;
    assign o_addr  = o_valid ? head.addr : addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: two instances (default base and a wrapping base) share one randomized stimulus stream,
// checked every cycle against a queue-based model, plus hand-computed literal expectations.
module tb_inst_encoder;

    localparam logic [31:0] BASE_B = 32'hFFFFFFF8;

    logic        clk = 1'b0;
    logic        rst, valid, rdy;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;

    logic        a_ready, a_valid, a_err;
    logic [31:0] a_inst, a_addr;
    logic        b_ready, b_valid, b_err;
    logic [31:0] b_inst, b_addr;

    always #5 clk = ~clk;

    inst_encoder dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(a_ready),
        .i_opcode(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
        .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
        .o_valid(a_valid), .i_ready(rdy), .o_inst(a_inst), .o_addr(a_addr), .o_err(a_err)
    );

    inst_encoder #(.BASE_ADDR(BASE_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(b_ready),
        .i_opcode(op), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
        .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
        .o_valid(b_valid), .i_ready(rdy), .o_inst(b_inst), .o_addr(b_addr), .o_err(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_inst [$];
    logic        q_err  [$];
    logic [31:0] q_seq  [$];
    logic [31:0] pushes = 32'd0;

    logic [6:0] op_tab [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};

    // Returns {err, word}, built from the format tables with shifts and masks.
    function automatic logic [32:0] ref_encode(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [2:0] fn3,
                                               input logic [6:0] fn7, input logic [31:0] im);
        int unsigned w, e, vo, vd, v1, v2, v3, v7, vi, i12;
        vo = o; vd = d; v1 = s1; v2 = s2; v3 = fn3; v7 = fn7; vi = im;
        e = 0;
        case (o)
            7'h37, 7'h17: w = (vi & 32'hFFFFF000) | (vd << 7) | vo;
            7'h6F: begin
                w = (((vi >> 20) & 1) << 31) | (((vi >> 1) & 32'h3FF) << 21) | (((vi >> 11) & 1) << 20)
                  | (((vi >> 12) & 32'hFF) << 12) | (vd << 7) | vo;
                e = vi & 1;
            end
            7'h67, 7'h03, 7'h13: begin
                i12 = vi & 32'hFFF;
                if (o == 7'h13 && (v3 == 1 || v3 == 5)) i12 = (v7 << 5) | (vi & 31);
                w = (i12 << 20) | (v1 << 15) | (v3 << 12) | (vd << 7) | vo;
            end
            7'h63: begin
                w = (((vi >> 12) & 1) << 31) | (((vi >> 5) & 32'h3F) << 25) | (v2 << 20) | (v1 << 15)
                  | (v3 << 12) | (((vi >> 1) & 32'hF) << 8) | (((vi >> 11) & 1) << 7) | vo;
                e = vi & 1;
            end
            7'h23: w = (((vi >> 5) & 32'h7F) << 25) | (v2 << 20) | (v1 << 15) | (v3 << 12)
                     | ((vi & 31) << 7) | vo;
            7'h33: w = (v7 << 25) | (v2 << 20) | (v1 << 15) | (v3 << 12) | (vd << 7) | vo;
            default: begin
                w = 32'h13;
                e = 1;
            end
        endcase
        return {e[0], w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q_inst.size();
        check("a_valid", a_valid, sz != 0);
        check("b_valid", b_valid, sz != 0);
        check("a_ready", a_ready, sz < 2);
        check("b_ready", b_ready, sz < 2);
        if (sz != 0) begin
            check("a_inst", a_inst, q_inst[0]);
            check("b_inst", b_inst, q_inst[0]);
            check("a_err", a_err, q_err[0]);
            check("b_err", b_err, q_err[0]);
            check("a_addr", a_addr, 32'd4 * q_seq[0]);
            check("b_addr", b_addr, BASE_B + 32'd4 * q_seq[0]);
        end else begin
            check("a_inst_empty", a_inst, 32'h0);
            check("b_inst_empty", b_inst, 32'h0);
            check("a_err_empty", a_err, 32'h0);
            check("b_err_empty", b_err, 32'h0);
            check("a_addr_empty", a_addr, 32'd4 * pushes);
            check("b_addr_empty", b_addr, BASE_B + 32'd4 * pushes);
        end
    endtask

    // Applies one cycle of inputs, advances the model at the edge, then compares at the falling edge.
    task automatic step(input logic r, input logic v, input logic rr, input logic [6:0] o,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] fn3, input logic [6:0] fn7, input logic [31:0] im);
        logic        do_pop, do_push;
        logic [32:0] enc;
        rst = r; valid = v; rdy = rr; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
        @(posedge clk);
        if (r) begin
            q_inst.delete(); q_err.delete(); q_seq.delete();
            pushes = 32'd0;
        end else begin
            do_pop  = (q_inst.size() != 0) && rr;
            do_push = v && (q_inst.size() < 2);
            if (do_pop) begin
                void'(q_inst.pop_front()); void'(q_err.pop_front()); void'(q_seq.pop_front());
            end
            if (do_push) begin
                enc = ref_encode(o, d, s1, s2, fn3, fn7, im);
                q_inst.push_back(enc[31:0]);
                q_err.push_back(enc[32]);
                q_seq.push_back(pushes);
                pushes = pushes + 32'd1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic r, input logic rr);
        step(r, 1'b0, rr, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    endtask

    task automatic push(input logic rr, input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [31:0] im);
        step(1'b0, 1'b1, rr, o, d, s1, s2, fn3, fn7, im);
    endtask

    initial begin
        logic [6:0]  r_op;
        logic [31:0] r_imm;
        rst = 1'b1; valid = 1'b0; rdy = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        f3 = '0; f7 = '0; imm = '0;
        @(negedge clk);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("rst_valid", a_valid, 32'd0);
        check("rst_ready", a_ready, 32'd1);
        check("rst_inst", a_inst, 32'd0);
        check("rst_addr_b", b_addr, 32'hFFFFFFF8);

        push(1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        check("lui_inst", a_inst, 32'h0007b2b7);
        check("lui_addr", a_addr, 32'h0);
        check("lui_err", a_err, 32'h0);
        idle(1'b0, 1'b1);

        idle(1'b1, 1'b0);
        push(1'b0, 7'h63, 5'd0, 5'd4, 5'd25, 3'b100, 7'd0, 32'd42);
        push(1'b0, 7'h23, 5'd0, 5'd2, 5'd14, 3'b010, 7'd0, 32'd23);
        check("full_ready", a_ready, 32'd0);
        push(1'b0, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
        check("held_b_inst", a_inst, 32'h03924563);
        check("held_b_addr", a_addr, 32'h0);
        idle(1'b0, 1'b1);
        check("s_inst", a_inst, 32'h00e12ba3);
        check("s_addr", a_addr, 32'h4);
        idle(1'b0, 1'b1);

        push(1'b1, 7'h33, 5'd3, 5'd1, 5'd15, 3'b100, 7'd0, 32'd0);
        check("xor_inst", a_inst, 32'h00f0c1b3);
        check("xor_addr", a_addr, 32'h8);
        push(1'b1, 7'h6F, 5'd23, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1232);
        check("jal_inst", a_inst, 32'h4d000bef);
        check("jal_addr", a_addr, 32'hC);

        push(1'b1, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd77);
        check("bad_inst", a_inst, 32'h00000013);
        check("bad_err", a_err, 32'h1);
        push(1'b1, 7'h6F, 5'd23, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1233);
        check("jodd_inst", a_inst, 32'h4d000bef);
        check("jodd_err", a_err, 32'h1);
        push(1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        check("legal_err", a_err, 32'h0);
        idle(1'b0, 1'b1);

        push(1'b0, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        push(1'b0, 7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        check("pre_rst_ready", a_ready, 32'd0);
        step(1'b1, 1'b1, 1'b1, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        check("mid_rst_valid", a_valid, 32'd0);
        check("mid_rst_ready", a_ready, 32'd1);
        push(1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0007b000);
        check("post_rst_addr_a", a_addr, 32'h0);
        check("post_rst_addr_b", b_addr, 32'hFFFFFFF8);
        check("post_rst_inst", a_inst, 32'h0007b2b7);

        idle(1'b1, 1'b1);
        push(1'b1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        check("wrap_addr0", b_addr, 32'hFFFFFFF8);
        push(1'b1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
        check("wrap_addr1", b_addr, 32'hFFFFFFFC);
        push(1'b1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3);
        check("wrap_addr2", b_addr, 32'h00000000);
        push(1'b1, 7'h13, 5'd9, 5'd8, 5'd0, 3'b101, 7'b0100000, 32'd7);
        check("srai_inst", a_inst, 32'h40745493);

        for (int i = 0; i < 3000; i++) begin
            r_op  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : op_tab[$urandom_range(0, 8)];
            r_imm = $urandom;
            if ((r_op == 7'h63 || r_op == 7'h6F) && $urandom_range(0, 3) != 0) r_imm[0] = 1'b0;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 r_op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), r_imm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
